// File: rtl/cla_accumulator.sv
// Multi-beat accumulator around a carry-lookahead adder: operands stream in over
// valid/ready, the running sum is folded through the adder, and the burst result leaves over valid/ready.

module carry_lookahead_adder #(
  parameter int G_WIDTH = 3
) (
  input  logic [G_WIDTH-1:0] i_add1,
  input  logic [G_WIDTH-1:0] i_add2,
  output logic [G_WIDTH:0]   o_result
);

  logic [G_WIDTH-1:0] w_g;
  logic [G_WIDTH-1:0] w_p;
  logic [G_WIDTH:0]   w_c;
  logic               w_term;

  assign w_g = i_add1 & i_add2;
  assign w_p = i_add1 ^ i_add2;

  // Each carry is the flat sum-of-products of generate/propagate terms, not a ripple chain.
  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    for (int i = 1; i <= G_WIDTH; i++) begin
      for (int j = 0; j < i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k < i; k++) begin
          w_term = w_term & w_p[k];
        end
        w_c[i] = w_c[i] | w_term;
      end
    end
  end

  assign o_result = {w_c[G_WIDTH], w_p ^ w_c[G_WIDTH-1:0]};

endmodule

module cla_accumulator #(
  parameter int G_WIDTH     = 3,
  parameter int G_CNT_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [G_WIDTH-1:0]     i_data,
  input  logic                   i_last,
  output logic [G_WIDTH-1:0]     o_add1,
  output logic [G_WIDTH-1:0]     o_add2,
  input  logic [G_WIDTH:0]       i_result,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [G_WIDTH-1:0]     o_sum,
  output logic                   o_ovf,
  output logic [G_CNT_WIDTH-1:0] o_count
);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_ADD    = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [G_CNT_WIDTH-1:0] LP_CNT_ONE = {{(G_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   r_state;
  state_t                   w_next_state;
  logic [G_WIDTH-1:0]       r_acc;
  logic [G_WIDTH-1:0]       r_op;
  logic                     r_last;
  logic                     r_ovf;
  logic [G_CNT_WIDTH-1:0]   r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_ACCEPT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake outputs decode only the state register, keeping inputs off every output path.
  always_comb begin
    w_next_state = r_state;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        o_ready = 1'b1;
        if (i_valid) w_next_state = S_ADD;
      end
      S_ADD: begin
        w_next_state = r_last ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_next_state = S_ACCEPT;
      end
      default: w_next_state = S_ACCEPT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_op   <= '0;
      r_last <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_ACCEPT: begin
          if (i_valid) begin
            r_op   <= i_data;
            r_last <= i_last;
            if (r_cnt != '1) r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        S_ADD: begin
          r_acc <= i_result[G_WIDTH-1:0];
          r_ovf <= r_ovf | i_result[G_WIDTH];
        end
        S_DONE: begin
          // Clearing on the handshake makes the next burst start from a zero accumulator.
          if (i_ready) begin
            r_acc <= '0;
            r_op  <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_add1  = r_acc;
  assign o_add2  = r_op;
  assign o_sum   = r_acc;
  assign o_ovf   = r_ovf;
  assign o_count = r_cnt;

endmodule

// File: tb/tb_cla_accumulator.sv
// Directed bench for cla_accumulator wired to a real carry_lookahead_adder:
// a table of bursts plus hand-written backpressure, reset and saturation sequences.

module tb_cla_accumulator;

  localparam int W  = 3;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_data;
  logic          i_last;
  logic [W-1:0]  o_add1;
  logic [W-1:0]  o_add2;
  logic [W:0]    w_result;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_sum;
  logic          o_ovf;
  logic [CW-1:0] o_count;

  carry_lookahead_adder #(.G_WIDTH(W)) u_add (
    .i_add1   (o_add1),
    .i_add2   (o_add2),
    .o_result (w_result)
  );

  cla_accumulator #(.G_WIDTH(W), .G_CNT_WIDTH(CW)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_last   (i_last),
    .o_add1   (o_add1),
    .o_add2   (o_add2),
    .i_result (w_result),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sum    (o_sum),
    .o_ovf    (o_ovf),
    .o_count  (o_count)
  );

  always #5 i_clk = ~i_clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] m_acc    = '0;

  typedef struct {
    string         name;
    logic [W-1:0]  ops [4];
    int            n;
    logic [W-1:0]  sum;
    logic          ovf;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs [7];
  int   n_vecs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d, input int n,
                         input logic [W-1:0] sum, input logic ovf, input logic [CW-1:0] cnt);
    vecs[n_vecs].name   = name;
    vecs[n_vecs].ops[0] = a;
    vecs[n_vecs].ops[1] = b;
    vecs[n_vecs].ops[2] = c;
    vecs[n_vecs].ops[3] = d;
    vecs[n_vecs].n      = n;
    vecs[n_vecs].sum    = sum;
    vecs[n_vecs].ovf    = ovf;
    vecs[n_vecs].cnt    = cnt;
    n_vecs++;
  endtask

  // Waits (bounded) for o_ready, hands over one beat, returns 1 time unit into S_ADD.
  // Junk stays on the bus during S_ADD to show it is ignored while o_ready is low.
  task automatic accept_beat(input logic [W-1:0] d, input logic last);
    int k = 0;
    while (o_ready !== 1'b1 && k < 10) begin
      @(posedge i_clk); #1;
      k++;
    end
    if (o_ready !== 1'b1) check("ready_timeout", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    @(posedge i_clk); #1;
    i_data = ~d;
    i_last = ~last;
    check("ready_low_in_add", {31'd0, o_ready}, 32'd0);
    check("add1_is_acc", {29'd0, o_add1}, {29'd0, m_acc});
    check("add2_is_op", {29'd0, o_add2}, {29'd0, d});
    m_acc = m_acc + d;
  endtask

  task automatic finish_beat(input logic last);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    if (last) check("valid_latency", {31'd0, o_valid}, 32'd1);
    else      check("ready_back", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic take_result(input string name, input logic [W-1:0] sum, input logic ovf,
                             input logic [CW-1:0] cnt);
    check({name, "_sum"}, {29'd0, o_sum}, {29'd0, sum});
    check({name, "_ovf"}, {31'd0, o_ovf}, {31'd0, ovf});
    check({name, "_count"}, {28'd0, o_count}, {28'd0, cnt});
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check({name, "_hs_valid_low"}, {31'd0, o_valid}, 32'd0);
    check({name, "_hs_ready"}, {31'd0, o_ready}, 32'd1);
    check({name, "_hs_sum_clear"}, {29'd0, o_sum}, 32'd0);
    m_acc = '0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, {31'd0, o_ready}, 32'd1);
    check({name, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({name, "_sum"}, {29'd0, o_sum}, 32'd0);
    check({name, "_ovf"}, {31'd0, o_ovf}, 32'd0);
    check({name, "_count"}, {28'd0, o_count}, 32'd0);
    check({name, "_add1"}, {29'd0, o_add1}, 32'd0);
    check({name, "_add2"}, {29'd0, o_add2}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add_vec("single5", 3'd5, 3'd0, 3'd0, 3'd0, 1, 3'd5, 1'b0, 4'd1);
    add_vec("b123",    3'd1, 3'd2, 3'd3, 3'd0, 3, 3'd6, 1'b0, 4'd3);
    add_vec("b56",     3'd5, 3'd6, 3'd0, 3'd0, 2, 3'd3, 1'b1, 4'd2);
    add_vec("b777",    3'd7, 3'd7, 3'd7, 3'd0, 3, 3'd5, 1'b1, 4'd3);
    add_vec("b4444",   3'd4, 3'd4, 3'd4, 3'd4, 4, 3'd0, 1'b1, 4'd4);
    add_vec("b0",      3'd0, 3'd0, 3'd0, 3'd0, 1, 3'd0, 1'b0, 4'd1);
    add_vec("b34",     3'd3, 3'd4, 3'd0, 3'd0, 2, 3'd7, 1'b0, 4'd2);

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Table-driven bursts.
    for (int v = 0; v < n_vecs; v++) begin
      for (int b = 0; b < vecs[v].n; b++) begin
        accept_beat(vecs[v].ops[b], b == vecs[v].n - 1);
        finish_beat(b == vecs[v].n - 1);
      end
      take_result(vecs[v].name, vecs[v].sum, vecs[v].ovf, vecs[v].cnt);
    end

    // Backpressure: result must hold while i_ready stays low.
    accept_beat(3'd2, 1'b0); finish_beat(1'b0);
    accept_beat(3'd2, 1'b1); finish_beat(1'b1);
    repeat (4) begin
      @(posedge i_clk); #1;
      check("bp_sum_stable", {29'd0, o_sum}, 32'd4);
      check("bp_valid_held", {31'd0, o_valid}, 32'd1);
      check("bp_ready_low", {31'd0, o_ready}, 32'd0);
      check("bp_count_stable", {28'd0, o_count}, 32'd2);
    end
    take_result("bp", 3'd4, 1'b0, 4'd2);
    accept_beat(3'd1, 1'b1); finish_beat(1'b1);
    take_result("after_bp", 3'd1, 1'b0, 4'd1);

    // Asynchronous reset in S_ADD of the last beat of burst 3, 4.
    accept_beat(3'd3, 1'b0); finish_beat(1'b0);
    accept_beat(3'd4, 1'b1);
    i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("rst_in_add");
    i_rst = 1'b0;
    m_acc = '0;
    @(posedge i_clk); #1;
    check("rst_burst_discarded", {31'd0, o_valid}, 32'd0);
    accept_beat(3'd2, 1'b0); finish_beat(1'b0);
    accept_beat(3'd2, 1'b1); finish_beat(1'b1);
    take_result("after_rst", 3'd4, 1'b0, 4'd2);

    // Asynchronous reset while the result is being presented.
    accept_beat(3'd6, 1'b1); finish_beat(1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("rst_in_done");
    i_rst = 1'b0;
    m_acc = '0;
    @(posedge i_clk); #1;

    // Beat counter saturates at 15 over a 17-beat burst of ones.
    for (int b = 0; b < 17; b++) begin
      accept_beat(3'd1, b == 16);
      finish_beat(b == 16);
    end
    take_result("saturate", 3'd1, 1'b1, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
